serial_sequence_generator_fsm: RTL and testbench
================================================

// Module: serial_sequence_generator_fsm
// PURPOSE
//   Serial pattern transmitter: on start, drives a fixed PATTERN of W bits MSB-first on one
//   output line, repeated a requested number of times, then pulses done. Bench and
//   self-test stimulus source for the serial sequence detectors.
//   Default pattern is "110011". Its output connects directly to a detector's 'a' input.
// PARAMETERS
//   W        6          pattern length in bits, legal 2..16
//   PATTERN  6'b110011  bit pattern; bit W-1 is transmitted first
//   CNT_W    4          width of repeat count
// PORTS
//   clk       in   1      clock, rising edge
//   rst       in   1      synchronous reset, active-high
//   start     in   1      request transmission; accepted only when ready=1
//   repeat_n  in   CNT_W  repetitions, sampled on accept; 0 is treated as 1
//   en        in   1      bit-advance enable (pacing tick) while sending
//   ready     out  1      idle, can accept start
//   a         out  1      serial data bit
//   valid     out  1      a carries a pattern bit this cycle
//   last      out  1      a is final bit of final repetition
//   done      out  1      one-cycle pulse after transmission completes
// BEHAVIOUR
//   - Single clock. Sync active-high rst, checked at posedge clk. rst has priority over all inputs.
//   - Reset values: state=IDLE, ready=1, a=0, valid=0, last=0, done=0, counters=0.
//   - States: IDLE, SEND, DONE (+GAP when SEQGEN_GAP_EN). Outputs are registered.
//   - IDLE: ready=1, valid=0, a=0. Accept start=1 -> capture reps=(repeat_n==0)?1:repeat_n,
//     bit index idx=0. Next state is SEND.
//     First bit appears on a/valid the cycle after acceptance, so latency is 1 cycle.
//   - SEND: valid=1, a=PATTERN[W-1-idx], ready=0. Advance only on en=1:
//       idx<W-1           -> idx+1
//       idx==W-1, reps>1  -> reps-1, idx=0. Next repetition follows back-to-back.
//       idx==W-1, reps==1 -> DONE
//     en=0: state, idx, reps, a, valid and last hold unchanged.
//   - last=1 in SEND when idx==W-1 and reps==1.
//   - DONE: lasts exactly one cycle. done=1, valid=0, a=0, ready=0. Next state is IDLE.
//     The next start can be accepted in the cycle after done.
//   - start in SEND/DONE is ignored and is not queued. repeat_n changes after accept have no effect.
//   - Total bits per job = W*reps. CNT_W=4 -> max 15 repetitions, 90 bits at W=6.
//   - rst mid-SEND: job aborted, reset values apply the next cycle, no done pulse.
//   - idx is $clog2(W) bits wide; no wrap beyond W-1 ever occurs.
// CONFIGURATION
//   SEQGEN_GAP_EN defined: one GAP cycle (valid=0, a=0) is inserted between repetitions.
//     GAP also advances only on en=1. No GAP after the final repetition.
//     Bits per job stay W*reps; duration is W*reps+(reps-1) en-cycles.
//   SEQGEN_GAP_EN undefined: repetitions are back-to-back and the GAP state does not exist.
// TESTING
//   1. rst=1 for 2 cycles, then idle -> ready=1, valid=0, a=0, done=0.
//   2. en=1, start with repeat_n=1 -> a=1,1,0,0,1,1 with valid=1 for cycles 1..6;
//      last=1 in cycle 6, done=1 in cycle 7, ready=1 in cycle 8.
//   3. en=1, repeat_n=2 -> 12 bits 110011110011 contiguous, single done pulse.
//      With SEQGEN_GAP_EN: one valid=0 cycle after bit 6.
//   4. repeat_n=0 -> behaves as repeat_n=1: 6 bits, then done.
//   5. en toggling 1,0,1,0… -> each bit held 2 cycles, 12-cycle job; start pulses mid-job ignored.
//   6. rst asserted at bit 3 of 6 -> next cycle ready=1, valid=0, and no done pulse.
//      Loopback into the 110011 detector in cases 2/3 -> detected asserts once per repetition.

Source files
------------

// File: rtl/serial_sequence_generator_fsm.sv
// Serial pattern transmitter: sends PATTERN MSB-first, repeated reps times, then pulses done.
// Optional feature macro: SEQGEN_GAP_EN inserts one idle GAP cycle between repetitions.
module serial_sequence_generator_fsm #(
    parameter int unsigned W       = 6,
    parameter logic [W-1:0] PATTERN = 6'b110011,
    parameter int unsigned CNT_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] repeat_n,
    input  logic             en,
    output logic             ready,
    output logic             a,
    output logic             valid,
    output logic             last,
    output logic             done
);

    localparam int unsigned IDX_W = $clog2(W);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(W - 1);

`ifdef SEQGEN_GAP_EN
    typedef enum logic [1:0] {IDLE, SEND, DONE, GAP} state_t;
`else
    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
`endif

    state_t           state, state_n;
    logic [IDX_W-1:0] idx, idx_n;
    logic [CNT_W-1:0] reps, reps_n;
    logic             ready_n, a_n, valid_n, last_n, done_n;

    // State, counters and registered outputs; rst wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            reps  <= '0;
            ready <= 1'b1;
            a     <= 1'b0;
            valid <= 1'b0;
            last  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            reps  <= reps_n;
            ready <= ready_n;
            a     <= a_n;
            valid <= valid_n;
            last  <= last_n;
            done  <= done_n;
        end
    end

    // Next state and counters; outputs are decoded from the next state so they register in step.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        reps_n  = reps;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = SEND;
                    idx_n   = '0;
                    reps_n  = (repeat_n == '0) ? CNT_W'(1) : repeat_n;
                end
            end
            SEND: begin
                if (en) begin
                    if (idx != IDX_LAST) begin
                        idx_n = idx + IDX_W'(1);
                    end else if (reps > CNT_W'(1)) begin
                        reps_n = reps - CNT_W'(1);
                        idx_n  = '0;
`ifdef SEQGEN_GAP_EN
                        state_n = GAP;
`endif
                    end else begin
                        state_n = DONE;
                    end
                end
            end
`ifdef SEQGEN_GAP_EN
            GAP: begin
                if (en) begin
                    state_n = SEND;
                end
            end
`endif
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase

        ready_n = (state_n == IDLE);
        done_n  = (state_n == DONE);
        valid_n = (state_n == SEND);
        a_n     = valid_n ? PATTERN[IDX_LAST - idx_n] : 1'b0;
        last_n  = valid_n && (idx_n == IDX_LAST) && (reps_n == CNT_W'(1));
    end

endmodule

// File: tb/tb_serial_sequence_generator_fsm.sv
// Directed self-checking bench for serial_sequence_generator_fsm (default W=6, PATTERN=110011).
module tb_serial_sequence_generator_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] repeat_n = 4'd0;
    logic       en = 1'b0;
    logic       ready, a, valid, last, done;

    int nvec = 0;
    int nerr = 0;

    // Hand-written expected pattern, bit 5 sent first.
    logic [5:0] pat = 6'b110011;

    serial_sequence_generator_fsm dut (
        .clk(clk), .rst(rst), .start(start), .repeat_n(repeat_n), .en(en),
        .ready(ready), .a(a), .valid(valid), .last(last), .done(done)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        nvec++;
        if ({ready, valid, a, last, done} !== 5'b10000) begin
            nerr++;
            $display("FAIL reset_held: got rdy/val/a/last/done=%b want 10000", {ready, valid, a, last, done});
        end
        rst = 1'b0;
        @(negedge clk);
        nvec++;
        if ({ready, valid, a, last, done} !== 5'b10000) begin
            nerr++;
            $display("FAIL reset_idle: got rdy/val/a/last/done=%b want 10000", {ready, valid, a, last, done});
        end
    endtask

    // Runs one en=1 job of nreps repetitions requested with rn; checks every cycle.
    task automatic run_job(input string name, input logic [3:0] rn, input int nreps);
        int bit_i;
        start = 1'b1; repeat_n = rn; en = 1'b1;
        @(negedge clk);
        start = 1'b0; repeat_n = 4'd7;
        for (int r = 0; r < nreps; r++) begin
            for (int i = 0; i < 6; i++) begin
                bit_i = r * 6 + i;
                nvec++;
                if (valid !== 1'b1 || a !== pat[5-i] || ready !== 1'b0 || done !== 1'b0 ||
                    last !== ((r == nreps - 1) && (i == 5))) begin
                    nerr++;
                    $display("FAIL %s bit%0d: got val=%b a=%b rdy=%b last=%b done=%b want val=1 a=%b rdy=0 last=%b done=0",
                             name, bit_i, valid, a, ready, last, done, pat[5-i], (r == nreps - 1) && (i == 5));
                end
                @(negedge clk);
            end
`ifdef SEQGEN_GAP_EN
            if (r != nreps - 1) begin
                nvec++;
                if (valid !== 1'b0 || a !== 1'b0 || done !== 1'b0 || ready !== 1'b0) begin
                    nerr++;
                    $display("FAIL %s gap%0d: got val=%b a=%b done=%b rdy=%b want 0000", name, r, valid, a, done, ready);
                end
                @(negedge clk);
            end
`endif
        end
        nvec++;
        if (done !== 1'b1 || valid !== 1'b0 || a !== 1'b0 || ready !== 1'b0) begin
            nerr++;
            $display("FAIL %s done_cycle: got done=%b val=%b a=%b rdy=%b want 1000", name, done, valid, a, ready);
        end
        @(negedge clk);
        nvec++;
        if (ready !== 1'b1 || done !== 1'b0 || valid !== 1'b0) begin
            nerr++;
            $display("FAIL %s back_idle: got rdy=%b done=%b val=%b want 100", name, ready, done, valid);
        end
    endtask

    task automatic test_single();
        run_job("single", 4'd1, 1);
    endtask

    task automatic test_repeat2();
        run_job("repeat2", 4'd2, 2);
    endtask

    task automatic test_repeat0();
        run_job("repeat0", 4'd0, 1);
    endtask

    task automatic test_back_to_back();
        // Start accepted in the very cycle ready returns.
        run_job("b2b_first", 4'd1, 1);
        run_job("b2b_second", 4'd3, 3);
    endtask

    // en alternates 0/1 so each bit is held two cycles; start pulses mid-job must be ignored.
    task automatic test_en_toggle();
        start = 1'b1; repeat_n = 4'd1; en = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            en = (c % 2 == 0);
            start = (c == 4 || c == 9);
            repeat_n = 4'd3;
            nvec++;
            if (valid !== 1'b1 || a !== pat[5-(c-1)/2] || last !== (c >= 11)) begin
                nerr++;
                $display("FAIL en_toggle c%0d: got val=%b a=%b last=%b want val=1 a=%b last=%b",
                         c, valid, a, last, pat[5-(c-1)/2], c >= 11);
            end
            @(negedge clk);
        end
        start = 1'b1;
        nvec++;
        if (done !== 1'b1 || valid !== 1'b0) begin
            nerr++;
            $display("FAIL en_toggle done: got done=%b val=%b want 10", done, valid);
        end
        @(negedge clk);
        start = 1'b0;
        nvec++;
        if (ready !== 1'b1 || valid !== 1'b0 || done !== 1'b0) begin
            nerr++;
            $display("FAIL en_toggle idle: got rdy=%b val=%b done=%b want 100", ready, valid, done);
        end
        @(negedge clk);
        nvec++;
        if (ready !== 1'b1 || valid !== 1'b0) begin
            nerr++;
            $display("FAIL en_toggle not_queued: got rdy=%b val=%b want 10", ready, valid);
        end
    endtask

    task automatic test_reset_mid();
        start = 1'b1; repeat_n = 4'd1; en = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        nvec++;
        if (valid !== 1'b1 || a !== 1'b0) begin
            nerr++;
            $display("FAIL rst_mid bit3: got val=%b a=%b want val=1 a=0", valid, a);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        nvec++;
        if ({ready, valid, a, last, done} !== 5'b10000) begin
            nerr++;
            $display("FAIL rst_mid after: got rdy/val/a/last/done=%b want 10000", {ready, valid, a, last, done});
        end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            nvec++;
            if (done !== 1'b0 || valid !== 1'b0 || ready !== 1'b1) begin
                nerr++;
                $display("FAIL rst_mid quiet%0d: got done=%b val=%b rdy=%b want 001", c, done, valid, ready);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_repeat2();
        test_repeat0();
        test_back_to_back();
        test_en_toggle();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
